fifo_arbiter: RTL and testbench

FIFO_ARBITER -- requirements
Module: fifo_arbiter

---
 rtl/fifo_arbiter.sv | 162 ++++++++++++++++
 tb/tb_fifo_arbiter.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_arbiter.sv
// PCI bus arbiter that queues requesting masters in arrival order and grants the queue head.
// Latency: grant 2 cycles after a request on an idle, empty arbiter; every output is registered.
// Backpressure: a full queue leaves requests level-pending; unused grants are revoked after TIMEOUT cycles.
module fifo_arbiter #(
    parameter int N_DEV   = 8,
    parameter int IDX_W   = 3,
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_DEV-1:0] req_n,
    input  logic             frame_n,
    input  logic             irdy_n,
    output logic [N_DEV-1:0] gnt_n,
    output logic [IDX_W-1:0] gnt_idx,
    output logic [IDX_W:0]   q_count,
    output logic             timeout_o
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [IDX_W:0]   DEPTH_C = (IDX_W + 1)'(DEPTH);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

    typedef enum logic [1:0] {IDLE, GRANT, BUSY} state_t;

    state_t           state_q, state_d;
    logic [N_DEV-1:0] gnt_n_q, gnt_n_d;
    logic [IDX_W-1:0] gnt_idx_q, gnt_idx_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [IDX_W:0]   count_q, count_d;
    logic [N_DEV-1:0] in_q_q, in_q_d;
    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             timeout_q, timeout_d;
    logic [IDX_W-1:0] mem_q [DEPTH];

    logic [IDX_W-1:0] head;
    logic [IDX_W-1:0] new_idx;
    logic             new_vld;
    logic             deq;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    assign head = mem_q[rd_ptr_q];

    // Descending scan so the lowest eligible index is the one left selected.
    always_comb begin
        new_vld = 1'b0;
        new_idx = '0;
        for (int i = N_DEV - 1; i >= 0; i--) begin
            if (!req_n[i] && !in_q_q[i] && (count_q < DEPTH_C) &&
                !((state_q != IDLE) && (gnt_idx_q == IDX_W'(i)))) begin
                new_vld = 1'b1;
                new_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        gnt_n_d   = gnt_n_q;
        gnt_idx_d = gnt_idx_q;
        tmo_cnt_d = tmo_cnt_q;
        timeout_d = 1'b0;
        deq       = 1'b0;
        case (state_q)
            IDLE: begin
                if (count_q != '0) begin
                    deq = 1'b1;
                    // A withdrawn head is dropped without ever being granted.
                    if (!req_n[head]) begin
                        state_d   = GRANT;
                        gnt_n_d   = ~(N_DEV'(1) << head);
                        gnt_idx_d = head;
                        tmo_cnt_d = '0;
                    end
                end
            end
            GRANT: begin
                if (!frame_n) begin
                    state_d = BUSY;
                    gnt_n_d = '1;
                end else if (req_n[gnt_idx_q]) begin
                    state_d = IDLE;
                    gnt_n_d = '1;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    state_d   = IDLE;
                    gnt_n_d   = '1;
                    timeout_d = 1'b1;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                end
            end
            BUSY: begin
                if (frame_n && irdy_n) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_n_d = '1;
            end
        endcase
    end

    always_comb begin
        wr_ptr_d = new_vld ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = deq ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q;
        if (new_vld && !deq) begin
            count_d = count_q + (IDX_W + 1)'(1);
        end else if (!new_vld && deq) begin
            count_d = count_q - (IDX_W + 1)'(1);
        end
        in_q_d = in_q_q;
        if (deq) begin
            in_q_d[head] = 1'b0;
        end
        if (new_vld) begin
            in_q_d[new_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            gnt_n_q   <= '1;
            gnt_idx_q <= '0;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            in_q_q    <= '0;
            tmo_cnt_q <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_n_q   <= gnt_n_d;
            gnt_idx_q <= gnt_idx_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
            in_q_q    <= in_q_d;
            tmo_cnt_q <= tmo_cnt_d;
            timeout_q <= timeout_d;
        end
    end

    always_ff @(posedge clk) begin
        if (new_vld && !rst) begin
            mem_q[wr_ptr_q] <= new_idx;
        end
    end

    assign gnt_n     = gnt_n_q;
    assign gnt_idx   = gnt_idx_q;
    assign q_count   = count_q;
    assign timeout_o = timeout_q;
endmodule

// File: tb/tb_fifo_arbiter.sv
// Arbiter bench: a queue-based reference model predicts grant/timeout events into a scoreboard,
// and a negedge monitor compares every DUT output against it while directed and random stimulus run.
module tb_fifo_arbiter;
    localparam int N   = 8;
    localparam int IW  = 3;
    localparam int DEP = 8;
    localparam int TMO = 16;
    localparam int S_IDLE  = 0;
    localparam int S_GRANT = 1;
    localparam int S_BUSY  = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  req_n;
    logic          frame_n;
    logic          irdy_n;
    logic [N-1:0]  gnt_n;
    logic [IW-1:0] gnt_idx;
    logic [IW:0]   q_count;
    logic          timeout_o;

    logic [3:0] req2_n;
    logic       frame2_n;
    logic       irdy2_n;
    logic [3:0] gnt2_n;
    logic [1:0] gnt2_idx;
    logic [2:0] q2_count;
    logic       timeout2;

    int n_checks = 0;
    int n_fail   = 0;

    int mq[$];
    int exp_q[$];
    int m_state = S_IDLE;
    int m_gidx  = 0;
    int m_tmo   = 0;
    bit m_tout  = 1'b0;

    always #5 clk = ~clk;

    fifo_arbiter #(.N_DEV(N), .IDX_W(IW), .DEPTH(DEP), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .req_n(req_n), .frame_n(frame_n), .irdy_n(irdy_n),
        .gnt_n(gnt_n), .gnt_idx(gnt_idx), .q_count(q_count), .timeout_o(timeout_o)
    );

    fifo_arbiter #(.N_DEV(4), .IDX_W(2), .DEPTH(2), .TIMEOUT(TMO)) dut2 (
        .clk(clk), .rst(rst), .req_n(req2_n), .frame_n(frame2_n), .irdy_n(irdy2_n),
        .gnt_n(gnt2_n), .gnt_idx(gnt2_idx), .q_count(q2_count), .timeout_o(timeout2)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic bit queued(input int d);
        foreach (mq[k]) if (mq[k] == d) return 1'b1;
        return 1'b0;
    endfunction

    // Reference model: whole-transaction rules applied once per rising edge.
    initial forever begin
        int pick;
        int h;
        @(posedge clk);
        if (rst) begin
            mq.delete();
            m_state = S_IDLE;
            m_gidx  = 0;
            m_tmo   = 0;
            m_tout  = 1'b0;
        end else begin
            pick = -1;
            if (mq.size() < DEP)
                for (int i = 0; i < N; i++)
                    if (pick < 0 && !req_n[i] && !queued(i) && !(m_state != S_IDLE && m_gidx == i))
                        pick = i;
            m_tout = 1'b0;
            case (m_state)
                S_IDLE: if (mq.size() > 0) begin
                    h = mq.pop_front();
                    if (!req_n[h]) begin
                        m_state = S_GRANT;
                        m_gidx  = h;
                        m_tmo   = 0;
                        exp_q.push_back(h);
                    end
                end
                S_GRANT: begin
                    if (!frame_n) m_state = S_BUSY;
                    else if (req_n[m_gidx]) m_state = S_IDLE;
                    else if (m_tmo == TMO - 1) begin
                        m_state = S_IDLE;
                        m_tout  = 1'b1;
                        exp_q.push_back(-1);
                    end else m_tmo++;
                end
                S_BUSY: if (frame_n && irdy_n) m_state = S_IDLE;
                default: m_state = S_IDLE;
            endcase
            if (pick >= 0) mq.push_back(pick);
        end
    end

    // Monitor: per-cycle output comparison plus event scoreboard.
    initial begin
        int prev_gnt;
        int e;
        prev_gnt = 'hFF;
        forever begin
            @(negedge clk);
            chk("q_count", int'(q_count), mq.size());
            chk("gnt_n", int'(gnt_n), (m_state == S_GRANT) ? ('hFF ^ (1 << m_gidx)) : 'hFF);
            chk("gnt_idx", int'(gnt_idx), m_gidx);
            chk("timeout_o", int'(timeout_o), int'(m_tout));
            if (int'(gnt_n) != 'hFF && prev_gnt == 'hFF) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : -99;
                chk("sb_grant", int'(gnt_idx), e);
            end
            if (timeout_o) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : -99;
                chk("sb_timeout", -1, e);
            end
            prev_gnt = int'(gnt_n);
        end
    end

    initial begin
        int pulses;
        int maxq;
        int t2;
        int got[$];
        rst = 1'b1; req_n = '1; frame_n = 1'b1; irdy_n = 1'b1;
        req2_n = '1; frame2_n = 1'b1; irdy2_n = 1'b1;
        tick(2);
        chk("rst_gnt_n", int'(gnt_n), 'hFF);
        chk("rst_gnt_idx", int'(gnt_idx), 0);
        chk("rst_q_count", int'(q_count), 0);
        chk("rst_timeout", int'(timeout_o), 0);

        // First request after reset: queued at edge 1, granted at edge 2.
        rst = 1'b0; req_n = 8'hFB;
        tick(1);
        chk("r37_q_count", int'(q_count), 1);
        chk("r37_gnt_wait", int'(gnt_n), 'hFF);
        tick(1);
        chk("r37_gnt_n", int'(gnt_n), 'hFB);
        chk("r37_gnt_idx", int'(gnt_idx), 2);
        req_n = '1;
        tick(3);

        // Two simultaneous requesters served lowest index first.
        req_n = 8'h7E;
        tick(2);
        chk("r38_gnt0", int'(gnt_n), 'hFE);
        chk("r38_q_after0", int'(q_count), 1);
        frame_n = 1'b0;
        tick(1);
        chk("r38_busy_gnt", int'(gnt_n), 'hFF);
        tick(2);
        chk("r38_no_requeue", int'(q_count), 1);
        frame_n = 1'b1; irdy_n = 1'b1;
        tick(2);
        chk("r38_gnt7", int'(gnt_n), 'h7F);
        chk("r38_idx7", int'(gnt_idx), 7);
        req_n = '1;
        tick(4);

        // Unused grant revoked after TIMEOUT cycles.
        req_n = 8'hF7;
        tick(2);
        chk("r39_gnt3", int'(gnt_n), 'hF7);
        pulses = 0;
        for (int i = 0; i < TMO; i++) begin
            tick(1);
            if (timeout_o) pulses++;
            if (i == TMO - 2) chk("r39_hold", int'(gnt_n), 'hF7);
        end
        chk("r39_revoked", int'(gnt_n), 'hFF);
        chk("r39_pulse", int'(timeout_o), 1);
        req_n = '1;
        tick(1);
        if (timeout_o) pulses++;
        chk("r39_pulse_count", pulses, 1);
        tick(2);

        // Queued entry withdrawn before it reaches the head of an idle arbiter.
        req_n = 8'hFD;
        tick(2);
        chk("r40_gnt1", int'(gnt_n), 'hFD);
        frame_n = 1'b0;
        tick(1);
        req_n = 8'hDF;
        tick(1);
        chk("r40_q_one", int'(q_count), 1);
        req_n = '1; frame_n = 1'b1; irdy_n = 1'b1;
        tick(1);
        chk("r40_q_still", int'(q_count), 1);
        tick(1);
        chk("r40_q_popped", int'(q_count), 0);
        chk("r40_no_gnt", int'(gnt_n), 'hFF);
        tick(1);
        chk("r40_no_gnt_later", int'(gnt_n), 'hFF);

        // Shallow queue: saturation and ascending service order.
        req2_n = 4'h0; maxq = 0; t2 = 0;
        for (int c = 0; c < 200 && got.size() < 4; c++) begin
            @(negedge clk);
            if (int'(q2_count) > maxq) maxq = int'(q2_count);
            if (timeout2) t2++;
            frame2_n = 1'b1;
            if (gnt2_n != 4'hF) begin
                got.push_back(int'(gnt2_idx));
                req2_n[gnt2_idx] = 1'b1;
                frame2_n = 1'b0;
            end
        end
        chk("r41_grants", got.size(), 4);
        foreach (got[k]) chk("r41_order", got[k], k);
        chk("r41_q_max", maxq, 2);
        chk("r41_no_timeout", t2, 0);
        req2_n = '1; frame2_n = 1'b1;
        tick(3);

        // Reset in the middle of a transfer with three entries queued.
        req_n = 8'hFE;
        tick(2);
        chk("r42_gnt0", int'(gnt_n), 'hFE);
        frame_n = 1'b0;
        tick(1);
        req_n = 8'hF0;
        tick(3);
        chk("r42_q3", int'(q_count), 3);
        rst = 1'b1;
        tick(1);
        chk("r42_gnt_n", int'(gnt_n), 'hFF);
        chk("r42_q0", int'(q_count), 0);
        chk("r42_timeout", int'(timeout_o), 0);
        rst = 1'b0; req_n = '1; frame_n = 1'b1; irdy_n = 1'b1;
        tick(2);
        chk("r42_q_after", int'(q_count), 0);

        // Random traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            for (int i = 0; i < N; i++)
                if ($urandom_range(31) == 0) req_n[i] = ~req_n[i];
            frame_n = ($urandom_range(11) != 0);
            irdy_n  = ($urandom_range(1) != 0);
            rst     = ($urandom_range(499) == 0);
        end
        rst = 1'b0; req_n = '1; frame_n = 1'b1; irdy_n = 1'b1;
        tick(40);
        chk("sb_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
